// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port RAM arbiter.
// The optional MEM_ARB_RR_EN round-robin mode uses owner_t for its last-winner register.
package mem_port_arbiter_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int RAM_LAT_MIN = 1;
    localparam int RAM_LAT_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch and load/store request/response bundle between the pipeline and the arbiter.
// Used unchanged whether or not MEM_ARB_RR_EN is defined.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W = INSTR_WIDTH
);
    logic              if_req;
    logic [DATA_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [DATA_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store accesses onto one single-port RAM with fixed read latency.
// Define MEM_ARB_RR_EN for round-robin on conflicts; otherwise D always beats IF.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W  = INSTR_WIDTH,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    mem_port_arbiter_if.slave bus,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [DATA_W-3:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [1:0] LAT_LOAD = 2'((RAM_LAT >= 2) ? (RAM_LAT - 2) : 0);

    arb_state_t state_reg;
    owner_t     owner_reg;
    logic [1:0] lat_cnt_reg;
    logic       live_reg;
    logic       can_grant;
    logic       d_wins;
    logic       if_gnt;
    logic       d_gnt;
    logic       rd_gnt;
    logic       unused_addr_lsbs;

    function automatic logic [DATA_W-1:0] route_rdata(input logic sel, input logic [DATA_W-1:0] data);
        return sel ? data : '0;
    endfunction

    // live_reg holds grants off for the one cycle after a reset edge so every output reads 0.
    assign can_grant = live_reg && (state_reg != ST_WAIT);

`ifdef MEM_ARB_RR_EN
    owner_t last_win_reg;
    assign d_wins = bus.d_req && (!bus.if_req || (last_win_reg == OWN_IF));
`else
    assign d_wins = bus.d_req;
`endif

    assign d_gnt  = can_grant && d_wins;
    assign if_gnt = can_grant && bus.if_req && !d_wins;
    assign rd_gnt = if_gnt || (d_gnt && !bus.d_we);

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = (state_reg == ST_RESP) && (owner_reg == OWN_IF);
    assign bus.d_rvalid  = (state_reg == ST_RESP) && (owner_reg == OWN_D);
    assign bus.if_rdata  = route_rdata(bus.if_rvalid, ram_rdata);
    assign bus.d_rdata   = route_rdata(bus.d_rvalid, ram_rdata);

    assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

    always_comb begin
        ram_en    = d_gnt || if_gnt;
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (d_gnt) begin
            ram_addr = bus.d_addr[DATA_W-1:2];
            if (bus.d_we) begin
                ram_we    = bus.d_be;
                ram_wdata = bus.d_wdata;
            end
        end else if (if_gnt) begin
            ram_addr = bus.if_addr[DATA_W-1:2];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            owner_reg   <= OWN_IF;
            lat_cnt_reg <= '0;
            live_reg    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_win_reg <= OWN_D;
`endif
        end else begin
            live_reg <= 1'b1;
            case (state_reg)
                ST_WAIT: begin
                    if (lat_cnt_reg == 2'd0) begin
                        state_reg <= ST_RESP;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 2'd1;
                    end
                end
                default: begin
                    // IDLE and RESP both accept a new grant; stores never leave IDLE.
                    if (rd_gnt) begin
                        owner_reg <= d_gnt ? OWN_D : OWN_IF;
                        if (RAM_LAT == 1) begin
                            state_reg <= ST_RESP;
                        end else begin
                            state_reg   <= ST_WAIT;
                            lat_cnt_reg <= LAT_LOAD;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
`ifdef MEM_ARB_RR_EN
            if (d_gnt || if_gnt) begin
                last_win_reg <= d_gnt ? OWN_D : OWN_IF;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with RAM_LAT=1 and one with RAM_LAT=3,
// each against a behavioural RAM and a cycle-level reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int NI   = 2;
    localparam int DW   = 32;
    localparam int MEMW = 256;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic          if_req   [NI];
    logic [DW-1:0] if_addr  [NI];
    logic          d_req    [NI];
    logic          d_we     [NI];
    logic [3:0]    d_be     [NI];
    logic [DW-1:0] d_addr   [NI];
    logic [DW-1:0] d_wdata  [NI];

    logic          if_gnt_w    [NI];
    logic          if_rvalid_w [NI];
    logic [DW-1:0] if_rdata_w  [NI];
    logic          d_gnt_w     [NI];
    logic          d_rvalid_w  [NI];
    logic [DW-1:0] d_rdata_w   [NI];
    logic          ram_en_w    [NI];
    logic [3:0]    ram_we_w    [NI];
    logic [DW-3:0] ram_addr_w  [NI];
    logic [DW-1:0] ram_wdata_w [NI];
    logic [DW-1:0] ram_rdata_w [NI];

    logic [DW-1:0] ram_mem  [NI][MEMW];
    logic [DW-1:0] ram_pipe [NI][4];
    logic [DW-1:0] ref_mem  [NI][MEMW];

    int            free_at    [NI];
    int            resp_at    [NI];
    logic          resp_own_d [NI];
    logic [DW-1:0] resp_dat   [NI];
    logic          last_d     [NI];
    logic          ifg_seen   [NI];
    logic          dg_seen    [NI];

    int cyc    = 0;
    bit armed  = 1'b0;
    int checks = 0;
    int errors = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        mem_port_arbiter_if #(.DATA_W(DW)) bus ();

        assign bus.if_req  = if_req[gi];
        assign bus.if_addr = if_addr[gi];
        assign bus.d_req   = d_req[gi];
        assign bus.d_we    = d_we[gi];
        assign bus.d_be    = d_be[gi];
        assign bus.d_addr  = d_addr[gi];
        assign bus.d_wdata = d_wdata[gi];

        assign if_gnt_w[gi]    = bus.if_gnt;
        assign if_rvalid_w[gi] = bus.if_rvalid;
        assign if_rdata_w[gi]  = bus.if_rdata;
        assign d_gnt_w[gi]     = bus.d_gnt;
        assign d_rvalid_w[gi]  = bus.d_rvalid;
        assign d_rdata_w[gi]   = bus.d_rdata;
        assign ram_rdata_w[gi] = ram_pipe[gi][lat_of(gi) - 1];

        mem_port_arbiter #(
            .DATA_W (DW),
            .RAM_LAT((gi == 0) ? 1 : 3)
        ) u_dut (
            .clk      (clk),
            .resetn   (resetn),
            .bus      (bus),
            .ram_en   (ram_en_w[gi]),
            .ram_we   (ram_we_w[gi]),
            .ram_addr (ram_addr_w[gi]),
            .ram_wdata(ram_wdata_w[gi]),
            .ram_rdata(ram_rdata_w[gi])
        );
    end

    // Behavioural RAM: read data emerges RAM_LAT edges after the enabled read, junk otherwise.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            for (int s = 3; s > 0; s--) ram_pipe[k][s] = ram_pipe[k][s-1];
            if (ram_en_w[k] && ram_we_w[k] == 4'b0) ram_pipe[k][0] = ram_mem[k][ram_addr_w[k][7:0]];
            else ram_pipe[k][0] = $urandom;
            if (ram_en_w[k]) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we_w[k][b]) ram_mem[k][ram_addr_w[k][7:0]][8*b +: 8] = ram_wdata_w[k][8*b +: 8];
            end
        end
    end

    task automatic chk(input int k, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL dut%0d %s cyc %0d: got %h expected %h", k, name, cyc, act, exp);
        end
    endtask

    // Reference model: a read granted in cycle t answers in t+L and blocks grants until then.
    always @(negedge clk) begin
        logic          e_ifg, e_dg, e_en, e_ifv, e_dv, dwin, can;
        logic [3:0]    e_we;
        logic [DW-3:0] e_addr;
        logic [DW-1:0] e_wd, e_ifd, e_dd;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            can    = (cyc >= free_at[k]);
            dwin   = d_req[k] && (!if_req[k] || (RR ? !last_d[k] : 1'b1));
            e_dg   = can && dwin;
            e_ifg  = can && if_req[k] && !dwin;
            e_en   = e_dg || e_ifg;
            e_addr = e_dg ? d_addr[k][DW-1:2] : (e_ifg ? if_addr[k][DW-1:2] : '0);
            e_we   = (e_dg && d_we[k]) ? d_be[k] : 4'b0;
            e_wd   = (e_dg && d_we[k]) ? d_wdata[k] : '0;
            e_ifv  = (resp_at[k] == cyc) && !resp_own_d[k];
            e_dv   = (resp_at[k] == cyc) && resp_own_d[k];
            e_ifd  = e_ifv ? resp_dat[k] : '0;
            e_dd   = e_dv ? resp_dat[k] : '0;
            if (armed) begin
                chk(k, "if_gnt",    {31'b0, if_gnt_w[k]},    {31'b0, e_ifg});
                chk(k, "d_gnt",     {31'b0, d_gnt_w[k]},     {31'b0, e_dg});
                chk(k, "if_rvalid", {31'b0, if_rvalid_w[k]}, {31'b0, e_ifv});
                chk(k, "d_rvalid",  {31'b0, d_rvalid_w[k]},  {31'b0, e_dv});
                chk(k, "if_rdata",  if_rdata_w[k],           e_ifd);
                chk(k, "d_rdata",   d_rdata_w[k],            e_dd);
                chk(k, "ram_en",    {31'b0, ram_en_w[k]},    {31'b0, e_en});
                chk(k, "ram_we",    {28'b0, ram_we_w[k]},    {28'b0, e_we});
                chk(k, "ram_addr",  {2'b0, ram_addr_w[k]},   {2'b0, e_addr});
                chk(k, "ram_wdata", ram_wdata_w[k],          e_wd);
            end
            ifg_seen[k] = if_gnt_w[k];
            dg_seen[k]  = d_gnt_w[k];
            if (e_dg && d_we[k]) begin
                for (int b = 0; b < 4; b++)
                    if (d_be[k][b]) ref_mem[k][d_addr[k][9:2]][8*b +: 8] = d_wdata[k][8*b +: 8];
            end
            if (!resetn) begin
                resp_at[k] = -1;
                free_at[k] = cyc + 2;
                last_d[k]  = 1'b1;
            end else begin
                if (e_en && !(e_dg && d_we[k])) begin
                    resp_at[k]    = cyc + lat_of(k);
                    free_at[k]    = cyc + lat_of(k);
                    resp_own_d[k] = e_dg;
                    resp_dat[k]   = ref_mem[k][e_dg ? d_addr[k][9:2] : if_addr[k][9:2]];
                end
                if (e_en) last_d[k] = e_dg;
            end
        end
        if (!resetn) armed = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] seq;
        for (int k = 0; k < NI; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
            d_be[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
            free_at[k] = 0; resp_at[k] = -1; resp_own_d[k] = 1'b0; resp_dat[k] = '0;
            last_d[k] = 1'b1; ifg_seen[k] = 1'b0; dg_seen[k] = 1'b0;
            for (int s = 0; s < 4; s++) ram_pipe[k][s] = '0;
            for (int i = 0; i < MEMW; i++) begin
                ram_mem[k][i] = 32'h1234_0000 | i;
                ref_mem[k][i] = 32'h1234_0000 | i;
            end
        end

        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        // Fetch to 0x10 on the LAT=1 port; first cycle after reset grants nothing.
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        @(negedge clk);
        chk(0, "rst_if_gnt", {31'b0, if_gnt_w[0]}, 32'd0);
        chk(0, "rst_ram_en", {31'b0, ram_en_w[0]}, 32'd0);
        tick(); @(negedge clk);
        chk(0, "t1_if_gnt",   {31'b0, if_gnt_w[0]}, 32'd1);
        chk(0, "t1_ram_addr", {2'b0, ram_addr_w[0]}, 32'h4);
        tick(); if_req[0] = 1'b0; @(negedge clk);
        chk(0, "t1_if_rvalid", {31'b0, if_rvalid_w[0]}, 32'd1);
        chk(0, "t1_if_rdata",  if_rdata_w[0], 32'h1234_0004);

        // Simultaneous load and fetch: D first, IF next cycle alongside D's response.
        tick();
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h20; if_req[0] = 1'b1; if_addr[0] = 32'h8;
        @(negedge clk);
        chk(0, "t2_d_gnt",    {31'b0, d_gnt_w[0]},  32'd1);
        chk(0, "t2_if_gnt0",  {31'b0, if_gnt_w[0]}, 32'd0);
        chk(0, "t2_ram_addr", {2'b0, ram_addr_w[0]}, 32'h8);
        tick(); d_req[0] = 1'b0; @(negedge clk);
        chk(0, "t2_d_rvalid",  {31'b0, d_rvalid_w[0]},  32'd1);
        chk(0, "t2_d_rdata",   d_rdata_w[0], 32'h1234_0008);
        chk(0, "t2_if_gnt1",   {31'b0, if_gnt_w[0]},    32'd1);
        chk(0, "t2_ram_addr2", {2'b0, ram_addr_w[0]},   32'h2);
        chk(0, "t2_if_rvalid", {31'b0, if_rvalid_w[0]}, 32'd0);
        tick(); if_req[0] = 1'b0; @(negedge clk);
        chk(0, "t2_if_rdata", if_rdata_w[0], 32'h1234_0002);

        // Partial store then back-to-back load of the same word.
        tick();
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_be[0] = 4'b0011; d_addr[0] = 32'h40; d_wdata[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk(0, "t3_ram_we",    {28'b0, ram_we_w[0]}, 32'h3);
        chk(0, "t3_ram_wdata", ram_wdata_w[0], 32'hDEAD_BEEF);
        tick(); d_we[0] = 1'b0; d_be[0] = 4'b0; d_wdata[0] = '0; @(negedge clk);
        chk(0, "t3_ld_gnt",      {31'b0, d_gnt_w[0]},    32'd1);
        chk(0, "t3_st_norvalid", {31'b0, d_rvalid_w[0]}, 32'd0);
        tick(); d_req[0] = 1'b0; @(negedge clk);
        chk(0, "t3_ld_rdata", d_rdata_w[0], 32'h1234_BEEF);

        // LAT=3 port: fetch blocks a pending load for two cycles.
        tick(); if_req[1] = 1'b1; if_addr[1] = 32'h10; @(negedge clk);
        chk(1, "t4_if_gnt", {31'b0, if_gnt_w[1]}, 32'd1);
        tick(); if_req[1] = 1'b0; d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h20; @(negedge clk);
        chk(1, "t4_d_gnt_t1", {31'b0, d_gnt_w[1]}, 32'd0);
        tick(); @(negedge clk);
        chk(1, "t4_d_gnt_t2", {31'b0, d_gnt_w[1]}, 32'd0);
        tick(); @(negedge clk);
        chk(1, "t4_if_rvalid", {31'b0, if_rvalid_w[1]}, 32'd1);
        chk(1, "t4_if_rdata",  if_rdata_w[1], 32'h1234_0004);
        chk(1, "t4_d_gnt_t3",  {31'b0, d_gnt_w[1]}, 32'd1);

        // Reset while that load is in flight; its response must never appear.
        tick(); d_req[1] = 1'b0; resetn = 1'b0;
        tick(); resetn = 1'b1; d_req[1] = 1'b1; d_addr[1] = 32'h40; @(negedge clk);
        chk(1, "t5_d_gnt0",    {31'b0, d_gnt_w[1]},    32'd0);
        chk(1, "t5_ram_en0",   {31'b0, ram_en_w[1]},   32'd0);
        chk(1, "t5_d_rvalid0", {31'b0, d_rvalid_w[1]}, 32'd0);
        tick(); @(negedge clk);
        chk(1, "t5_new_gnt",      {31'b0, d_gnt_w[1]},    32'd1);
        chk(1, "t5_stale_rvalid", {31'b0, d_rvalid_w[1]}, 32'd0);
        tick(); d_req[1] = 1'b0;
        tick(); tick(); @(negedge clk);
        chk(1, "t5_d_rvalid", {31'b0, d_rvalid_w[1]}, 32'd1);
        chk(1, "t5_d_rdata",  d_rdata_w[1], 32'h1234_0010);

        // Both requests held: fixed priority gives D every time, round-robin alternates from IF.
        tick();
        if_req[0] = 1'b1; if_addr[0] = 32'h8; d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h20;
        seq = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seq[i] = d_gnt_w[0];
            tick();
        end
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        chk(0, "t6_grant_order", {28'b0, seq}, RR ? 32'hA : 32'hF);
        repeat (4) tick();

        for (int c = 0; c < 4000; c++) begin
            tick();
            resetn = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < NI; k++) begin
                if (!if_req[k] || ifg_seen[k]) begin
                    if_req[k]  = ($urandom_range(0, 2) != 0);
                    if_addr[k] = $urandom_range(0, 1023);
                end
                if (!d_req[k] || dg_seen[k]) begin
                    d_req[k]   = ($urandom_range(0, 2) != 0);
                    d_we[k]    = ($urandom_range(0, 2) == 0);
                    d_be[k]    = 4'($urandom);
                    d_addr[k]  = $urandom_range(0, 1023);
                    d_wdata[k] = $urandom;
                end
            end
        end
        resetn = 1'b1;
        for (int k = 0; k < NI; k++) begin
            if_req[k] = 1'b0;
            d_req[k]  = 1'b0;
        end
        repeat (6) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
